// File: rtl/dmem_responder_pkg.sv
// Shared load/store encodings and responder state type for the data-memory path.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MEM_READ_NONE   = 3'd0,
    MEM_READ_BYTE   = 3'd1,
    MEM_READ_HALF   = 3'd2,
    MEM_READ_WORD   = 3'd3,
    MEM_READ_BYTE_U = 3'd4,
    MEM_READ_HALF_U = 3'd5
  } mem_read_t;

  typedef enum logic [1:0] {
    MEM_WRITE_NONE = 2'd0,
    MEM_WRITE_BYTE = 2'd1,
    MEM_WRITE_HALF = 2'd2,
    MEM_WRITE_WORD = 2'd3
  } mem_write_t;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

  localparam logic [31:0] BAD_VAL = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_responder_load_extender.sv
// Selects the addressed byte/half of a memory word and sign/zero-extends it for a load.
module load_extender
  import dmem_responder_pkg::*;
(
  input  logic [31:0] rdword,
  input  logic [1:0]  lane,
  input  mem_read_t   op,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdword >> {lane, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane[1] ? rdword[31:16] : rdword[15:0];
    data    = '0;
    case (op)
      MEM_READ_BYTE:   data = {{24{byte_v[7]}}, byte_v};
      MEM_READ_HALF:   data = {{16{half_v[15]}}, half_v};
      MEM_READ_WORD:   data = rdword;
      MEM_READ_BYTE_U: data = {24'd0, byte_v};
      MEM_READ_HALF_U: data = {16'd0, half_v};
      default:         data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word SRAM with programmable latency,
// byte-lane stores, extended loads and access-fault reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_read,
  input  logic [1:0]  req_write,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t state, state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  mem_read_t     rd_q;
  mem_write_t    wr_q;
  logic [31:0]   wd_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          rerr_q;

  logic [31:0] mem [DEPTH_WORDS];

  mem_read_t   rd_in;
  mem_write_t  wr_in;
  logic [31:0] offset;
  logic        req_err;
  logic        accept;
  logic        enter_resp;

  logic [AW-1:0] cur_idx;
  logic [1:0]    cur_lane;
  mem_read_t     cur_rd;
  mem_write_t    cur_wr;
  logic [31:0]   cur_wd;
  logic          cur_err;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic [31:0]   rd_word;
  logic [31:0]   ext_data;

  always_comb begin
    rd_in  = mem_read_t'(req_read);
    wr_in  = mem_write_t'(req_write);
    offset = req_addr - BASE_ADDR;
    req_err = 1'b0;
    if (rd_in != MEM_READ_NONE && wr_in != MEM_WRITE_NONE)
      req_err = 1'b1;
    else if (req_read == 3'b110 || req_read == 3'b111)
      req_err = 1'b1;
    else if ((rd_in == MEM_READ_HALF || rd_in == MEM_READ_HALF_U || wr_in == MEM_WRITE_HALF)
             && req_addr[0])
      req_err = 1'b1;
    else if ((rd_in == MEM_READ_WORD || wr_in == MEM_WRITE_WORD) && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    else if ((offset >> 2) >= DEPTH_WORDS)
      req_err = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = (state == DMEM_IDLE);
    resp_valid = (state == DMEM_RESP);
    case (state)
      DMEM_IDLE: if (req_valid) state_nxt = (LATENCY > 0) ? DMEM_WAIT : DMEM_RESP;
      DMEM_WAIT: if (cnt == '0) state_nxt = DMEM_RESP;
      DMEM_RESP: if (resp_ready) state_nxt = DMEM_IDLE;
      default:   state_nxt = DMEM_IDLE;
    endcase
  end

  assign accept     = req_valid && (state == DMEM_IDLE);
  assign enter_resp = (state_nxt == DMEM_RESP) && (state != DMEM_RESP);

  // With zero latency RESP is entered on the accept edge itself, so the
  // commit/read path must see the live request rather than the latched copy.
  always_comb begin
    if (state == DMEM_IDLE) begin
      cur_idx  = offset[AW+1:2];
      cur_lane = req_addr[1:0];
      cur_rd   = rd_in;
      cur_wr   = wr_in;
      cur_wd   = req_wdata;
      cur_err  = req_err;
    end else begin
      cur_idx  = idx_q;
      cur_lane = lane_q;
      cur_rd   = rd_q;
      cur_wr   = wr_q;
      cur_wd   = wd_q;
      cur_err  = err_q;
    end
  end

  always_comb begin
    be   = '0;
    wdat = cur_wd;
    case (cur_wr)
      MEM_WRITE_BYTE: begin
        be   = 4'b0001 << cur_lane;
        wdat = {4{cur_wd[7:0]}};
      end
      MEM_WRITE_HALF: begin
        be   = cur_lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{cur_wd[15:0]}};
      end
      MEM_WRITE_WORD: be = '1;
      default:        be = '0;
    endcase
  end

  assign rd_word = mem[cur_idx];

  load_extender u_ext (
    .rdword (rd_word),
    .lane   (cur_lane),
    .op     (cur_rd),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DMEM_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      rd_q    <= MEM_READ_NONE;
      wr_q    <= MEM_WRITE_NONE;
      wd_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= LAT_LOAD;
        idx_q  <= offset[AW+1:2];
        lane_q <= req_addr[1:0];
        rd_q   <= rd_in;
        wr_q   <= wr_in;
        wd_q   <= req_wdata;
        err_q  <= req_err;
      end else if (state == DMEM_WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rerr_q  <= cur_err;
        rdata_q <= cur_err ? BAD_VAL : ext_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && !cur_err) begin
      for (int unsigned i = 0; i < 4; i++)
        if (be[i]) mem[cur_idx][8*i +: 8] <= wdat[8*i +: 8];
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-addressed reference model checked every response cycle.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_read = '0;
  logic [1:0]  req_write = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;

  logic        rr_a, rv_a, re_a, rr_b, rv_b, re_b;
  logic [31:0] rd_a, rd_b;
  logic        cur_req_ready, cur_resp_valid, cur_resp_err;
  logic [31:0] cur_resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // dut_a: 1024 words at 0, latency 1; dut_b: 16 words at 0x8000_0000, latency 0
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rr_a),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_err(re_a));

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDR(32'h8000_0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rr_b),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_err(re_b));

  assign cur_req_ready  = sel ? rr_b : rr_a;
  assign cur_resp_valid = sel ? rv_b : rv_a;
  assign cur_resp_rdata = sel ? rd_b : rd_a;
  assign cur_resp_err   = sel ? re_b : re_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        s;
    logic [31:0] addr;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] wd;
    int          acc;
  } req_t;

  req_t        pend[$];
  logic [7:0]  bmem [longint];
  logic        have_exp = 1'b0;
  logic [31:0] exp_d;
  logic        exp_e;

  function automatic longint bkey(input logic s, input logic [31:0] a);
    return (s ? 64'h1_0000_0000 : 64'h0) + longint'(a);
  endfunction

  task automatic model(input req_t r, output logic [31:0] d, output logic e);
    logic [31:0] base, off, v;
    int unsigned depth, n;
    logic mis;
    base  = r.s ? 32'h8000_0000 : 32'h0;
    depth = r.s ? 16 : 1024;
    off   = r.addr - base;
    mis   = ((r.rd == 3'd2 || r.rd == 3'd5 || r.wr == 2'd2) && r.addr[0]) ||
            ((r.rd == 3'd3 || r.wr == 2'd3) && r.addr[1:0] != 2'b00);
    e = (r.rd != 3'd0 && r.wr != 2'd0) || r.rd >= 3'd6 || mis || (off / 4 >= depth);
    d = 32'h0;
    if (e) begin
      d = 32'hDEAD_BEEF;
    end else if (r.wr != 2'd0) begin
      n = (r.wr == 2'd1) ? 1 : (r.wr == 2'd2) ? 2 : 4;
      for (int unsigned i = 0; i < n; i++) bmem[bkey(r.s, off + i)] = r.wd[8*i +: 8];
    end else if (r.rd != 3'd0) begin
      n = (r.rd == 3'd1 || r.rd == 3'd4) ? 1 : (r.rd == 3'd3) ? 4 : 2;
      v = 0;
      for (int unsigned i = 0; i < n; i++)
        if (bmem.exists(bkey(r.s, off + i))) v = v | (32'(bmem[bkey(r.s, off + i)]) << (8 * i));
      if (r.rd == 3'd1 && v[7])  v = v | 32'hFFFF_FF00;
      if (r.rd == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
      d = v;
    end
  endtask

  always @(negedge clk) begin
    req_t r;
    if (!rst_n) begin
      chk("rst_req_ready_a", rr_a, 1); chk("rst_resp_valid_a", rv_a, 0);
      chk("rst_rdata_a", rd_a, 0);     chk("rst_err_a", re_a, 0);
      chk("rst_req_ready_b", rr_b, 1); chk("rst_resp_valid_b", rv_b, 0);
      pend.delete();
      have_exp = 1'b0;
    end else begin
      if (req_valid && cur_req_ready)
        pend.push_back('{s: sel, addr: req_addr, rd: req_read, wr: req_write, wd: req_wdata, acc: cyc});
      if (cur_resp_valid) begin
        if (!have_exp) begin
          if (pend.size() == 0) begin
            chk("unexpected_resp", cur_resp_valid, 0);
          end else begin
            r = pend.pop_front();
            model(r, exp_d, exp_e);
            have_exp = 1'b1;
            chk("mdl_latency", cyc - r.acc, (r.s ? 0 : 1) + 1);
          end
        end
        if (have_exp) begin
          chk("mdl_rdata", cur_resp_rdata, exp_d);
          chk("mdl_err", cur_resp_err, exp_e);
          chk("mdl_req_ready_busy", cur_req_ready, 0);
        end
        if (resp_ready) have_exp = 1'b0;
      end
    end
  end

  // ---------------- directed driver ----------------
  task automatic xact(input logic s, input logic [31:0] addr, input logic [2:0] rd,
                      input logic [1:0] wr, input logic [31:0] wd, input int hold,
                      input logic [31:0] e_d, input logic e_e, input int e_lat);
    int k;
    sel = s; req_addr = addr; req_read = rd; req_write = wr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~addr; req_read = 3'd0; req_write = 2'd0; req_wdata = ~wd;
    k = 1;
    while (!cur_resp_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    if (!cur_resp_valid) begin
      chk("resp_timeout", cur_resp_valid, 1);
      return;
    end
    if (e_lat > 0) chk("lat", k, e_lat);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", cur_resp_valid, 1);
      chk("hold_req_ready", cur_req_ready, 0);
      chk("hold_rdata", cur_resp_rdata, e_d);
      @(posedge clk); #1;
    end
    chk("rdata", cur_resp_rdata, e_d);
    chk("err", cur_resp_err, e_e);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_valid", cur_resp_valid, 0);
    chk("post_req_ready", cur_req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // store / load word, latency 1
    xact(0, 32'h10, MEM_READ_NONE, MEM_WRITE_WORD, 32'h1122_3344, 0, 32'h0, 0, 2);
    xact(0, 32'h10, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'h1122_3344, 0, 2);
    // byte store into a zero word, extended byte loads
    xact(0, 32'h10, MEM_READ_NONE, MEM_WRITE_WORD, 32'h0, 0, 32'h0, 0, 0);
    xact(0, 32'h13, MEM_READ_NONE, MEM_WRITE_BYTE, 32'h1234_56AB, 0, 32'h0, 0, 0);
    xact(0, 32'h13, MEM_READ_BYTE, MEM_WRITE_NONE, 32'h0, 0, 32'hFFFF_FFAB, 0, 0);
    xact(0, 32'h13, MEM_READ_BYTE_U, MEM_WRITE_NONE, 32'h0, 0, 32'h0000_00AB, 0, 0);
    xact(0, 32'h10, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'hAB00_0000, 0, 0);
    // halfword store / loads
    xact(0, 32'h14, MEM_READ_NONE, MEM_WRITE_WORD, 32'hFFFF_FFFF, 0, 32'h0, 0, 0);
    xact(0, 32'h16, MEM_READ_NONE, MEM_WRITE_HALF, 32'h1234_8001, 0, 32'h0, 0, 0);
    xact(0, 32'h16, MEM_READ_HALF, MEM_WRITE_NONE, 32'h0, 0, 32'hFFFF_8001, 0, 0);
    xact(0, 32'h14, MEM_READ_HALF_U, MEM_WRITE_NONE, 32'h0, 0, 32'h0000_FFFF, 0, 0);
    xact(0, 32'h14, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'h8001_FFFF, 0, 0);
    // faults
    xact(0, 32'h11, MEM_READ_HALF, MEM_WRITE_NONE, 32'h0, 0, 32'hDEAD_BEEF, 1, 0);
    xact(0, 32'h12, MEM_READ_NONE, MEM_WRITE_WORD, 32'h55, 0, 32'hDEAD_BEEF, 1, 0);
    xact(0, 32'h1000, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'hDEAD_BEEF, 1, 0);
    xact(0, 32'h10, 3'b111, MEM_WRITE_NONE, 32'h0, 0, 32'hDEAD_BEEF, 1, 0);
    xact(0, 32'h10, MEM_READ_WORD, MEM_WRITE_WORD, 32'h99, 0, 32'hDEAD_BEEF, 1, 0);
    xact(0, 32'h10, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'hAB00_0000, 0, 0);
    // no-op takes full latency; back-pressure holds response
    xact(0, 32'h10, MEM_READ_NONE, MEM_WRITE_NONE, 32'hFFFF_FFFF, 0, 32'h0, 0, 2);
    xact(0, 32'h10, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 5, 32'hAB00_0000, 0, 2);
    xact(0, 32'hFFC, MEM_READ_NONE, MEM_WRITE_WORD, 32'h7777_0001, 0, 32'h0, 0, 0);
    xact(0, 32'hFFC, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'h7777_0001, 0, 0);

    // zero-latency instance, range edges and wrap below base
    xact(1, 32'h8000_0004, MEM_READ_NONE, MEM_WRITE_WORD, 32'hCAFE_F00D, 0, 32'h0, 0, 1);
    xact(1, 32'h8000_0004, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'hCAFE_F00D, 0, 1);
    xact(1, 32'h8000_0040, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'hDEAD_BEEF, 1, 1);
    xact(1, 32'h7FFF_FFFC, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'hDEAD_BEEF, 1, 1);
    xact(1, 32'h8000_003C, MEM_READ_NONE, MEM_WRITE_WORD, 32'h0102_0304, 0, 32'h0, 0, 1);
    xact(1, 32'h8000_003C, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 2, 32'h0102_0304, 0, 1);

    // reset during WAIT aborts an uncommitted store
    xact(0, 32'h20, MEM_READ_NONE, MEM_WRITE_WORD, 32'h0BAD_F00D, 0, 32'h0, 0, 0);
    xact(0, 32'h20, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'h0BAD_F00D, 0, 0);
    sel = 0; req_addr = 32'h20; req_read = 3'd0; req_write = MEM_WRITE_WORD;
    req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("in_wait_busy", cur_req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_now_req_ready", cur_req_ready, 1);
    chk("rst_now_resp_valid", cur_resp_valid, 0);
    chk("rst_now_rdata", cur_resp_rdata, 32'h0);
    chk("rst_now_err", cur_resp_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 32'h20, MEM_READ_WORD, MEM_WRITE_NONE, 32'h0, 0, 32'h0BAD_F00D, 0, 2);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
